spi_target: RTL and testbench
=============================

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter W, default 32 (`W_CPU), word length in bits per frame.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on sclk, cs and mosi.
REQ-003 clk  input  1  system clock; all state is updated on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 spi_clk  input  1  SPI serial clock from initiator, asynchronous to clk, idle low (mode 0).
REQ-006 spi_cs  input  1  chip select from initiator, active-high.
REQ-007 spi_mosi  input  1  serial data from initiator, MSB first.
REQ-008 spi_miso  output  1  serial data to initiator, MSB first.
REQ-009 tx_data  input  W  word to return on the next frame.
REQ-010 tx_valid  input  1  tx_data is valid; transfer occurs when tx_valid and tx_ready are both high on a clk edge.
REQ-011 tx_ready  output  1  single-entry transmit buffer is empty.
REQ-012 rx_data  output  W  last completely received word, held until the next word completes.
REQ-013 rx_valid  output  1  one-clk pulse: rx_data has been updated.
REQ-014 tx_underrun  output  1  one-clk pulse: a word started with the transmit buffer empty.
REQ-015 frame_err  output  1  one-clk pulse: spi_cs deasserted with a partial word (1..W-1 bits) received.

Function
REQ-016 spi_clk, spi_cs and spi_mosi SHALL pass through SYNC_STAGES flops; edges are detected on the synchronized signals only.
REQ-017 The block SHALL operate correctly when spi_clk high and low phases each last >= SYNC_STAGES+2 clk periods.
REQ-018 The FSM SHALL have the states IDLE, LOAD, SHIFT and DONE.
REQ-019 IDLE->LOAD on the synchronized rising edge of spi_cs; LOAD->SHIFT after exactly 1 clk.
REQ-020 In LOAD, a full buffer SHALL be moved into the tx shift register and empty the buffer; an empty buffer SHALL load zeros and pulse tx_underrun.
REQ-021 spi_miso SHALL present the shift-register MSB from the end of LOAD, i.e. before the first spi_clk rising edge.
REQ-022 In SHIFT, each synchronized spi_clk rising edge SHALL shift spi_mosi into the LSB of the rx shift register and increment the bit counter.
REQ-023 In SHIFT, each synchronized spi_clk falling edge SHALL shift the tx register left by 1, except the falling edge that follows bit W.
REQ-024 When the bit counter reaches W, the FSM SHALL enter DONE: rx_data <= rx shift register, rx_valid pulses 1 clk later than that rising edge is detected, and the counter clears to 0.
REQ-025 From DONE, with spi_cs still high, the next falling edge of spi_clk SHALL cause DONE->LOAD, allowing back-to-back words without deasserting cs.
REQ-026 From DONE, on spi_cs deassertion, the FSM SHALL go to IDLE with no error.
REQ-027 Synchronized spi_cs deassertion in SHIFT with counter 1..W-1 SHALL:
- discard the partial word,
- pulse frame_err,
- leave rx_data unchanged,
- return to IDLE.
REQ-028 Synchronized spi_cs deassertion in SHIFT with counter 0 SHALL return to IDLE silently.
REQ-029 spi_miso SHALL drive 0 in IDLE.
REQ-030 tx_ready = buffer empty; if tx_valid is high in the same clk that LOAD empties the buffer, the new word SHALL be captured for the following frame.
REQ-031 rx has no backpressure; the host must consume rx_data within one word time.

Reset
REQ-032 The block SHALL reset asynchronously with rst high. Reset values:
- FSM = IDLE
- counter = 0
- shift registers, tx buffer and synchronizers = 0
- tx_ready = 1
- rx_data = 0
- rx_valid, tx_underrun, frame_err and spi_miso = 0
REQ-033 rst mid-frame SHALL abort the word with no pulses; after rst falls, operation SHALL resume only on a fresh spi_cs rising edge.

Structure
REQ-034 FSM state encodings and the SPI widths SHALL live in the shared SPI package/header, alongside `W_CPU and `W_SPI_CTRL.
REQ-035 One sub-module, spi_sync (an N-stage synchronizer with edge-detect outputs), SHALL be instantiated three times.

Verification
REQ-036 Single word: tx 0xA5A5_5A5A, initiator sends 0x1234_5678 -> rx_data=0x12345678 with one rx_valid pulse; initiator captures 0xA5A55A5A.
REQ-037 Back-to-back: two words with cs held high and tx words 0x1, 0x2 preloaded in turn -> two rx_valid pulses; miso returns 0x00000001 then 0x00000002.
REQ-038 Underrun: tx buffer empty at cs rise -> tx_underrun pulses once; miso returns 0x00000000; rx still correct.
REQ-039 Abort: cs drops after 13 bits -> frame_err pulses; rx_valid stays 0; rx_data keeps its previous value.
REQ-040 Reset mid-frame: rst asserted after 20 bits -> all outputs at reset values, tx_ready=1; the next full frame receives correctly.
REQ-041 Handshake race: tx_valid asserted in the LOAD clk -> the word is captured and sent in the next frame; tx_ready drops for 1..n clks.

Source files
------------

// File: rtl/spi_target_pkg.sv
// Shared SPI definitions: word widths, FSM state encoding and counter sizing.
`ifndef W_CPU
`define W_CPU 32
`endif
`ifndef W_SPI_CTRL
`define W_SPI_CTRL 8
`endif

package spi_target_pkg;

  localparam int SPI_W_DEFAULT    = `W_CPU;
  localparam int SPI_CTRL_W       = `W_SPI_CTRL;
  localparam int SPI_SYNC_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spi_state_e;

  // Bit counter must hold 0..W.
  function automatic int spi_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage synchronizer for one asynchronous input, with rise/fall strobes
// derived from the synchronized level.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              q_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain  <= '0;
      q_prev <= 1'b0;
    end else begin
      chain  <= (chain << 1) | STAGES'(d);
      q_prev <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled by clk, W-bit words MSB first, single-entry
// transmit buffer, back-to-back words while chip select stays high.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int W           = SPI_W_DEFAULT,
  parameter int SYNC_STAGES = SPI_SYNC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         spi_clk,
  input  logic         spi_cs,
  input  logic         spi_mosi,
  output logic         spi_miso,
  input  logic [W-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic [W-1:0] rx_data,
  output logic         rx_valid,
  output logic         tx_underrun,
  output logic         frame_err
);

  localparam int CW = spi_cnt_w(W);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(spi_clk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .d(spi_cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_q, cs_fall, mosi_rise, mosi_fall};

  // After reset the synchronizers refill from zero, which would fake a cs
  // rising edge if cs was held high; only accept a frame start once cs has
  // been seen low with the synchronizer pipeline settled.
  logic [SYNC_STAGES:0] settle;
  logic                 armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[SYNC_STAGES-1:0], 1'b1};
      if (settle[SYNC_STAGES] && !cs_q) armed <= 1'b1;
    end
  end

  spi_state_e      state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            load_en, rx_shift, tx_shift, word_done, abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_en   = 1'b0;
    rx_shift  = 1'b0;
    tx_shift  = 1'b0;
    word_done = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: if (cs_rise && armed) state_nxt = LOAD;
      LOAD: begin
        load_en   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (!cs_q) begin
          abort     = (cnt != '0);
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (sclk_rise) begin
          rx_shift = 1'b1;
          if (cnt == CW'(W - 1)) begin
            word_done = 1'b1;
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (sclk_fall) begin
          tx_shift = 1'b1;
        end
      end
      DONE: begin
        if (!cs_q)          state_nxt = IDLE;
        else if (sclk_fall) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [W-1:0] tx_sr, rx_sr, buf_data;
  logic         buf_full, load_take, tx_accept;

  // A word offered in the same clk that LOAD drains the buffer is kept.
  assign load_take = load_en & buf_full;
  assign tx_accept = tx_valid & (~buf_full | load_take);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      rx_data     <= '0;
      buf_data    <= '0;
      buf_full    <= 1'b0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid    <= word_done;
      frame_err   <= abort;
      tx_underrun <= load_en & ~buf_full;

      if (load_en)       tx_sr <= buf_full ? buf_data : '0;
      else if (tx_shift) tx_sr <= {tx_sr[W-2:0], 1'b0};

      if (rx_shift)  rx_sr   <= {rx_sr[W-2:0], mosi_q};
      if (word_done) rx_data <= {rx_sr[W-2:0], mosi_q};

      if (tx_accept) begin
        buf_full <= 1'b1;
        buf_data <= tx_data;
      end else if (load_take) begin
        buf_full <= 1'b0;
      end
    end
  end

  assign tx_ready = ~buf_full;
  assign spi_miso = (state != IDLE) && tx_sr[W-1];

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: an SPI mode-0 initiator driven against a transaction
// level model of the transmit buffer, received words and event pulses.
module tb_spi_target;

  localparam int W    = 32;
  localparam int HALF = 65;

  logic         clk = 1'b0, rst = 1'b1;
  logic         spi_clk = 1'b0, spi_cs = 1'b0, spi_mosi = 1'b0, spi_miso;
  logic [W-1:0] tx_data = '0, rx_data;
  logic         tx_valid = 1'b0, tx_ready, rx_valid, tx_underrun, frame_err;

  int checks = 0, passes = 0, fails = 0;
  int n_rxv = 0, n_und = 0, n_ferr = 0;

  // Model: buffer contents, word queued for the next word slot, last rx word.
  bit           m_full = 1'b0;
  logic [W-1:0] m_data = '0, m_rx = '0, pend_miso = '0;
  int           e_rxv = 0, e_und = 0, e_ferr = 0;

  spi_target #(.W(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid)    n_rxv++;
      if (tx_underrun) n_und++;
      if (frame_err)   n_ferr++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A word slot starts: it takes the buffered word, or zeros with an underrun.
  task automatic model_load();
    pend_miso = m_full ? m_data : '0;
    if (!m_full) e_und++;
    m_full = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] d);
    for (int n = 0; n < 200 && !tx_ready; n++) @(negedge clk);
    check("push_ready", W'(tx_ready), W'(1));
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    m_full   = 1'b1;
    m_data   = d;
  endtask

  task automatic spi_xfer(input logic [W-1:0] mw, input int nbits, input bit keep,
                          output logic [W-1:0] got);
    got = '0;
    if (!spi_cs) begin
      spi_cs = 1'b1;
      #(2 * HALF);
    end
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mw[W-1-i];
      #(HALF);
      spi_clk = 1'b1;
      got = {got[W-2:0], spi_miso};
      #(HALF);
      spi_clk = 1'b0;
    end
    #(HALF);
    if (!keep) begin
      spi_cs = 1'b0;
      #(2 * HALF);
    end
  endtask

  // A full word ends with a falling edge while cs is high, which opens the
  // next word slot immediately; a partial word dropped by cs is an error.
  task automatic run_frame(input string tag, input logic [W-1:0] mw, input int nbits,
                           input bit keep);
    logic [W-1:0] got, exp_miso;
    if (!spi_cs) model_load();
    exp_miso = pend_miso;
    spi_xfer(mw, nbits, keep, got);
    if (nbits == W) begin
      m_rx = mw;
      e_rxv++;
      model_load();
      check({tag, "_miso"}, got, exp_miso);
    end else if (!keep && nbits > 0) begin
      e_ferr++;
    end
    check({tag, "_rx_data"}, rx_data, m_rx);
    check({tag, "_rx_valid_cnt"}, W'(n_rxv), W'(e_rxv));
    check({tag, "_underrun_cnt"}, W'(n_und), W'(e_und));
    check({tag, "_frame_err_cnt"}, W'(n_ferr), W'(e_ferr));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_ready"},    W'(tx_ready), W'(1));
    check({tag, "_rx_data"},     rx_data, '0);
    check({tag, "_rx_valid"},    W'(rx_valid), '0);
    check({tag, "_tx_underrun"}, W'(tx_underrun), '0);
    check({tag, "_frame_err"},   W'(frame_err), '0);
    check({tag, "_miso"},        W'(spi_miso), '0);
  endtask

  logic [W-1:0] junk, rw;
  bit           rk;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (6) @(negedge clk);

    push(32'hA5A5_5A5A);
    run_frame("single", 32'h1234_5678, W, 1'b0);

    // Back-to-back: second word queued while the first is on the wire.
    push(32'h0000_0001);
    @(negedge clk);
    spi_cs = 1'b1;
    model_load();
    for (int n = 0; n < 50 && !tx_ready; n++) @(negedge clk);
    check("b2b_buffer_drained", W'(tx_ready), W'(1));
    push(32'h0000_0002);
    run_frame("b2b_w0", 32'hCAFE_F00D, W, 1'b1);
    run_frame("b2b_w1", 32'h8000_0001, W, 1'b0);

    check("undr_ready", W'(tx_ready), W'(1));
    run_frame("underrun", 32'h0F0F_3C3C, W, 1'b0);

    run_frame("abort13", 32'hFFFF_FFFF, 13, 1'b0);

    // Reset in the middle of a word, with cs still high afterwards.
    push(32'h1357_9BDF);
    run_frame("pre_rst", 32'h2468_ACE0, 20, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    m_full = 1'b0;
    m_rx   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    spi_xfer(32'hFFFF_FFFF, 8, 1'b1, junk);
    spi_cs = 1'b0;
    #(2 * HALF);
    check("post_rst_rx_valid_cnt", W'(n_rxv), W'(e_rxv));
    check("post_rst_underrun_cnt", W'(n_und), W'(e_und));
    check("post_rst_frame_err_cnt", W'(n_ferr), W'(e_ferr));
    check("post_rst_rx_data", rx_data, '0);
    push(32'h600D_F00D);
    run_frame("after_rst", 32'h0BAD_CAFE, W, 1'b0);

    // Offer a new word exactly in the clk that drains the buffer.
    push(32'hC0DE_0001);
    @(negedge clk);
    spi_cs = 1'b1;
    model_load();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tx_data  = 32'hC0DE_0002;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    m_full   = 1'b1;
    m_data   = 32'hC0DE_0002;
    check("race_ready_low", W'(tx_ready), '0);
    run_frame("race_w0", 32'h5555_AAAA, W, 1'b1);
    check("race_ready_back", W'(tx_ready), W'(1));
    run_frame("race_w1", 32'hAAAA_5555, W, 1'b0);

    for (int i = 0; i < 8; i++) begin
      if (!m_full && $urandom_range(0, 1) == 1) push($urandom);
      rw = $urandom;
      rk = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_frame("rnd", rw, W, rk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
